// File: rtl/aes_decrypt_iterative.sv
// aes_decrypt_iterative: iterative AES-128 decryption, one inverse round per clock.
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               begin a decryption; sampled only while busy is low
//   key_in [127:0]      cipher key (round key 0), byte 0 in the MSBs
//   data_in [127:0]     ciphertext block, same byte order
//   busy                high while an operation is in progress
//   done                one-cycle pulse; data_out is valid in that cycle
//   data_out [127:0]    plaintext, held until the next done
// Optional feature: define AES_DEC_KEY_CACHE_EN to cache the last key and its
// round key 10, so that a repeated key skips the forward key expansion.

module inv_byte_substitution (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign byte_o = INV_SBOX[byte_i];
endmodule

module aes_decrypt_iterative (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 40'd0
  };
  typedef enum logic [2:0] {IDLE, KEYEXP, ARK, ROUND, FINAL} state_e;
  state_e       fsm_q;
  logic [127:0] key_q, state_q, data_q;
  logic [3:0]   rc_q;
  logic         busy_q, done_q;
  logic [31:0]  sw_in, sw, fw0, fw1, fw2, fw3;
  logic [127:0] key_fwd_d, key_inv_d, isr, isb, round_d, final_d;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key_q, cache_k10_q;
  logic         cache_valid_q;
  logic         hit;
  assign hit = cache_valid_q && key_in == cache_key_q;
`endif

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant whose bits select the x, 2x, 4x, 8x terms.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[0] ? a : 8'h00);
  endfunction

  // Byte i sits at bits [127-8i -: 8]; row = i % 4, column = i / 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
      o[119-32*c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
      o[111-32*c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
      o[103-32*c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    end
    return o;
  endfunction

  // One SubWord(RotWord()) serves both schedules: forward uses a3, inverse uses b3 = a3^a2.
  assign sw_in     = fsm_q == KEYEXP ? key_q[31:0] : key_q[31:0] ^ key_q[63:32];
  assign sw        = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {RCON[rc_q], 24'd0};
  assign fw0       = key_q[127:96] ^ sw;
  assign fw1       = key_q[95:64] ^ fw0;
  assign fw2       = key_q[63:32] ^ fw1;
  assign fw3       = key_q[31:0] ^ fw2;
  assign key_fwd_d = {fw0, fw1, fw2, fw3};
  assign key_inv_d = {key_q[127:96] ^ sw, key_q[95:64] ^ key_q[127:96],
                      key_q[63:32] ^ key_q[95:64], key_q[31:0] ^ key_q[63:32]};

  assign isr = inv_shift_rows(state_q);
  for (genvar i = 0; i < 16; i++) begin : g_isb
    inv_byte_substitution u_isb (.byte_i(isr[127-8*i -: 8]), .byte_o(isb[127-8*i -: 8]));
  end
  assign final_d = isb ^ key_q;
  assign round_d = inv_mix_columns(final_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      key_q   <= '0;
      state_q <= '0;
      data_q  <= '0;
      rc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_q   <= '0;
      cache_k10_q   <= '0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: if (start) begin
          state_q <= data_in;
          busy_q  <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (hit) begin
            key_q <= cache_k10_q;
            rc_q  <= 4'd10;
            fsm_q <= ARK;
          end else begin
            key_q         <= key_in;
            rc_q          <= 4'd1;
            fsm_q         <= KEYEXP;
            cache_key_q   <= key_in;
            cache_valid_q <= 1'b0;
          end
`else
          key_q <= key_in;
          rc_q  <= 4'd1;
          fsm_q <= KEYEXP;
`endif
        end
        KEYEXP: begin
          key_q <= key_fwd_d;
          if (rc_q == 4'd10) begin
            fsm_q <= ARK;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_k10_q   <= key_fwd_d;
            cache_valid_q <= 1'b1;
`endif
          end else
            rc_q <= rc_q + 4'd1;
        end
        // rc stays 10 here so the inverse step uses Rcon(10) to derive k9.
        ARK: begin
          state_q <= state_q ^ key_q;
          key_q   <= key_inv_d;
          rc_q    <= 4'd9;
          fsm_q   <= ROUND;
        end
        ROUND: begin
          state_q <= round_d;
          key_q   <= key_inv_d;
          rc_q    <= rc_q - 4'd1;
          if (rc_q == 4'd1) fsm_q <= FINAL;
        end
        FINAL: begin
          data_q <= final_d;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_q;
endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// tb_aes_decrypt_iterative: checks the decryptor against FIPS-197 vectors and a forward AES model.
module tb_aes_decrypt_iterative;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [127:0] key_in = '0, data_in = '0;
  logic         busy, done;
  logic [127:0] data_out;
  int           tests = 0, fails = 0;
  logic [7:0]   sb [256];
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT = 11;
`else
  localparam int HIT = 21;
`endif
  localparam logic [127:0] C1_K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_K    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_decrypt_iterative dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, a;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      a = inv;
      for (int k = 0; k < 4; k++) begin
        a = rotl(a);
        inv ^= a;
      end
      sb[x] = inv ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'd0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] rk, o;
    rk = rkey(k, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = sb[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = t[4*c+r];
        for (int r = 0; r < 4; r++)
          s[4*c+r] = rnd == 10 ? a[r] :
                     gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
      rk = rkey(k, rnd);
      for (int i = 0; i < 16; i++) s[i] ^= rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic go(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt,
                    input logic [127:0] k10, input int lat, input bit ghost);
    int n;
    key_in  = k;
    data_in = ct;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    data_in = ~ct;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_during_run", 128'(busy), 128'd1);
      if (n == 10 && lat == 21) chk("k10_probe", dut.key_q, k10);
      if (ghost && n == 4) begin
        key_in  = ~k;
        data_in = {4{$urandom}};
        start   = 1'b1;
      end
      if (ghost && n == 5) begin
        start  = 1'b0;
        key_in = k;
      end
    end
    chk("latency", 128'(n), 128'(lat));
    chk("plaintext", data_out, pt);
    chk("busy_in_done_cycle", 128'(busy), 128'd0);
  endtask

  task automatic no_done(input int cyc);
    int c;
    c = 0;
    repeat (cyc) begin
      @(posedge clk);
      @(negedge clk);
      if (done) c++;
    end
    chk("no_extra_done", 128'(c), 128'd0);
  endtask

  initial begin
    logic [127:0] k, pt;
    build_sbox();
    repeat (2) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_data_out", data_out, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    go(C1_K, C1_CT, C1_PT, C1_K10, 21, 1'b0);
    go(B_K, B_CT, B_PT, B_K10, 21, 1'b1);
    no_done(30);
    go(C1_K, C1_CT, C1_PT, C1_K10, 21, 1'b0);
    go(C1_K, C1_CT, C1_PT, C1_K10, HIT, 1'b1);
    go(B_K, B_CT, B_PT, B_K10, 21, 1'b0);
    for (int i = 0; i < 3; i++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      go(k, encrypt(k, pt), pt, rkey(k, 10), 21, 1'b0);
      pt = {$urandom, $urandom, $urandom, $urandom};
      go(k, encrypt(k, pt), pt, rkey(k, 10), HIT, i == 1);
    end
    go(C1_K, C1_CT, C1_PT, C1_K10, 21, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(C1_K, C1_CT, C1_PT, C1_K10, 21, 1'b0);
    go(B_K, B_CT, B_PT, B_K10, 21, 1'b0);
    key_in  = C1_K;
    data_in = C1_CT;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_data_out", data_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done(30);
    go(C1_K, C1_CT, C1_PT, C1_K10, 21, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
